// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore FSM sequencing fetch, decode, ALU, load/store and halt for a 16-bit CPU datapath.
// RAM reads are timed by a shared wait counter that runs RAM_LAT cycles in S_FETCH and S_MRD.
module cpu_controller #(
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       load_pc,
    output logic       pc_sel,
    output logic       load_ir,
    output logic       load_addr,
    output logic       addr_sel,
    output logic       ram_w_en,
    output logic [2:0] nsel,
    output logic       w_en,
    output logic [1:0] wb_sel,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       sel_A,
    output logic       waiting,
    output logic       halted
);

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_IR, S_DEC, S_WIMM, S_GA, S_GB, S_EX, S_WB,
        S_MGB, S_MEX, S_MADR, S_MRD, S_MWB, S_SGB, S_SEX, S_SWR, S_HALT
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(RAM_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mov_q, mov_d;
    logic       cmp_q, cmp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            mov_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mov_q   <= mov_d;
            cmp_q   <= cmp_d;
        end
    end

    // Instruction class is latched in S_DEC so S_EX outputs depend on registered state only.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mov_d   = mov_q;
        cmp_d   = cmp_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == CNT_LAST) state_d = S_IR;
                else                   cnt_d   = 3'(cnt_q + 3'd1);
            end
            S_IR:    state_d = S_DEC;
            S_DEC: begin
                mov_d = ({opcode, op} == 5'b110_00) || ({opcode, op} == 5'b101_11);
                cmp_d = ({opcode, op} == 5'b101_01);
                case ({opcode, op})
                    5'b110_10:                       state_d = S_WIMM;
                    5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GA;
                    5'b110_00, 5'b101_11:            state_d = S_GB;
                    5'b011_00, 5'b100_00:            state_d = S_MGB;
                    default:                         state_d = S_HALT;
                endcase
            end
            S_WIMM:  state_d = S_FETCH;
            S_GA:    state_d = S_GB;
            S_GB:    state_d = S_EX;
            S_EX:    state_d = cmp_q ? S_FETCH : S_WB;
            S_WB:    state_d = S_FETCH;
            S_MGB:   state_d = S_MEX;
            S_MEX:   state_d = S_MADR;
            S_MADR:  state_d = (opcode == 3'b011) ? S_MRD : S_SGB;
            S_MRD: begin
                if (cnt_q == CNT_LAST) state_d = S_MWB;
                else                   cnt_d   = 3'(cnt_q + 3'd1);
            end
            S_MWB:   state_d = S_FETCH;
            S_SGB:   state_d = S_SEX;
            S_SEX:   state_d = S_SWR;
            S_SWR:   state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        load_pc   = 1'b0;
        pc_sel    = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        ram_w_en  = 1'b0;
        nsel      = 3'b000;
        w_en      = 1'b0;
        wb_sel    = 2'b00;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        waiting   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_RST:   load_pc = 1'b1;
            S_FETCH: begin
                addr_sel = 1'b1;
                waiting  = (cnt_q == 3'd0);
            end
            S_IR: begin
                addr_sel = 1'b1;
                load_ir  = 1'b1;
            end
            S_DEC: begin
                load_pc = 1'b1;
                pc_sel  = 1'b1;
            end
            S_WIMM: begin
                nsel   = 3'b001;
                wb_sel = 2'b10;
                w_en   = 1'b1;
            end
            S_GA: begin
                nsel = 3'b001;
                en_A = 1'b1;
            end
            S_GB: begin
                nsel = 3'b100;
                en_B = 1'b1;
            end
            S_EX: begin
                sel_A     = mov_q;
                en_status = cmp_q;
                en_C      = ~cmp_q;
            end
            S_WB: begin
                nsel = 3'b010;
                w_en = 1'b1;
            end
            S_MGB: begin
                nsel = 3'b001;
                en_B = 1'b1;
            end
            S_MEX, S_SEX: begin
                sel_A = 1'b1;
                en_C  = 1'b1;
            end
            S_MADR:  load_addr = 1'b1;
            S_MWB: begin
                nsel   = 3'b010;
                wb_sel = 2'b01;
                w_en   = 1'b1;
            end
            S_SGB: begin
                nsel = 3'b010;
                en_B = 1'b1;
            end
            S_SWR:   ram_w_en = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - Directed self-checking bench for cpu_controller at RAM_LAT=1 and RAM_LAT=3.
module tb_cpu_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst3;
    logic [2:0] opcode, opcode3;
    logic [1:0] op, op3;

    logic       load_pc, pc_sel, load_ir, load_addr, addr_sel, ram_w_en, w_en;
    logic [2:0] nsel;
    logic [1:0] wb_sel;
    logic       en_A, en_B, en_C, en_status, sel_A, waiting, halted;

    logic       load_pc3, pc_sel3, load_ir3, load_addr3, addr_sel3, ram_w_en3, w_en3;
    logic [2:0] nsel3;
    logic [1:0] wb_sel3;
    logic       en_A3, en_B3, en_C3, en_status3, sel_A3, waiting3, halted3;

    cpu_controller #(.RAM_LAT(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .op(op),
        .load_pc(load_pc), .pc_sel(pc_sel), .load_ir(load_ir), .load_addr(load_addr),
        .addr_sel(addr_sel), .ram_w_en(ram_w_en), .nsel(nsel), .w_en(w_en), .wb_sel(wb_sel),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status), .sel_A(sel_A),
        .waiting(waiting), .halted(halted)
    );

    cpu_controller #(.RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .opcode(opcode3), .op(op3),
        .load_pc(load_pc3), .pc_sel(pc_sel3), .load_ir(load_ir3), .load_addr(load_addr3),
        .addr_sel(addr_sel3), .ram_w_en(ram_w_en3), .nsel(nsel3), .w_en(w_en3), .wb_sel(wb_sel3),
        .en_A(en_A3), .en_B(en_B3), .en_C(en_C3), .en_status(en_status3), .sel_A(sel_A3),
        .waiting(waiting3), .halted(halted3)
    );

    localparam int B_LPC = 18, B_PCS = 17, B_LIR = 16, B_LAD = 15, B_AS = 14, B_RW = 13;
    localparam int B_WEN = 9, B_EA = 6, B_EB = 5, B_EC = 4, B_ES = 3, B_SA = 2, B_WT = 1, B_HLT = 0;

    logic [18:0] o1, o3;
    assign o1 = {load_pc, pc_sel, load_ir, load_addr, addr_sel, ram_w_en, nsel, w_en, wb_sel,
                 en_A, en_B, en_C, en_status, sel_A, waiting, halted};
    assign o3 = {load_pc3, pc_sel3, load_ir3, load_addr3, addr_sel3, ram_w_en3, nsel3, w_en3, wb_sel3,
                 en_A3, en_B3, en_C3, en_status3, sel_A3, waiting3, halted3};

    int errors = 0;
    int checks = 0;
    int c_cyc, c_ea, c_eb, c_ec, c_wen, c_st, c_sa, c_rw_a0, c_ldwb, c_zero, c_halt, c_strobe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        c_cyc = 0; c_ea = 0; c_eb = 0; c_ec = 0; c_wen = 0; c_st = 0; c_sa = 0;
        c_rw_a0 = 0; c_ldwb = 0; c_zero = 0; c_halt = 0; c_strobe = 0;
    endtask

    task automatic tally(input logic [18:0] o);
        c_ea  += int'(o[B_EA]);
        c_eb  += int'(o[B_EB]);
        c_ec  += int'(o[B_EC]);
        c_wen += int'(o[B_WEN]);
        c_st  += int'(o[B_ES]);
        c_sa  += int'(o[B_SA]);
        c_halt += int'(o[B_HLT]);
        if (o[B_RW] && !o[B_AS]) c_rw_a0++;
        if (o[B_WEN] && o[8:7] == 2'b01) c_ldwb++;
        if (o == 19'd0) c_zero++;
        if ((o & ~19'd1) != 19'd0) c_strobe++;
    endtask

    // Runs from a negedge where waiting is high until waiting is seen again (or budget expires).
    task automatic measure(input bit which, input int budget);
        logic [18:0] o;
        clear_counts();
        o = which ? o3 : o1;
        do begin
            tally(o);
            @(negedge clk);
            c_cyc++;
            o = which ? o3 : o1;
        end while (!o[B_WT] && c_cyc < budget);
    endtask

    task automatic observe(input int n);
        clear_counts();
        for (int i = 0; i < n; i++) begin
            tally(o1);
            @(negedge clk);
            c_cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        opcode = 3'b110; op = 2'b10;
        opcode3 = 3'b011; op3 = 2'b00;

        repeat (2) @(negedge clk);
        check("rst_load_pc", 32'(load_pc), 32'd1);
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_others", 32'(o1 & ~(19'd1 << B_LPC)), 32'd0);

        // MOV R0,#7
        rst = 1'b0;
        @(negedge clk);
        check("mov_waiting_c1", 32'(waiting), 32'd1);
        check("mov_fetch_addr_sel", 32'(addr_sel), 32'd1);
        @(negedge clk);
        check("mov_ir_load_ir", 32'(load_ir), 32'd1);
        @(negedge clk);
        check("mov_dec_pc", 32'({load_pc, pc_sel}), 32'd3);
        @(negedge clk);
        check("mov_wimm_nsel", 32'(nsel), 32'd1);
        check("mov_wimm_wb_sel", 32'(wb_sel), 32'd2);
        check("mov_wimm_w_en", 32'(w_en), 32'd1);
        @(negedge clk);
        check("mov_waiting_again", 32'(waiting), 32'd1);

        // ADD
        opcode = 3'b101; op = 2'b00;
        measure(1'b0, 40);
        check("add_cycles", 32'(c_cyc), 32'd7);
        check("add_en_A", 32'(c_ea), 32'd1);
        check("add_en_B", 32'(c_eb), 32'd1);
        check("add_en_C", 32'(c_ec), 32'd1);
        check("add_w_en", 32'(c_wen), 32'd1);
        check("add_sel_A", 32'(c_sa), 32'd0);

        // CMP
        op = 2'b01;
        measure(1'b0, 40);
        check("cmp_cycles", 32'(c_cyc), 32'd6);
        check("cmp_en_status", 32'(c_st), 32'd1);
        check("cmp_w_en", 32'(c_wen), 32'd0);
        check("cmp_en_C", 32'(c_ec), 32'd0);

        // MVN
        op = 2'b11;
        measure(1'b0, 40);
        check("mvn_cycles", 32'(c_cyc), 32'd6);
        check("mvn_sel_A", 32'(c_sa), 32'd1);
        check("mvn_en_A", 32'(c_ea), 32'd0);

        // STR
        opcode = 3'b100; op = 2'b00;
        measure(1'b0, 40);
        check("str_cycles", 32'(c_cyc), 32'd9);
        check("str_ram_w_en_addr0", 32'(c_rw_a0), 32'd1);
        check("str_w_en", 32'(c_wen), 32'd0);

        // LDR at RAM_LAT=1
        opcode = 3'b011;
        measure(1'b0, 40);
        check("ldr1_cycles", 32'(c_cyc), 32'd8);
        check("ldr1_wb_ram", 32'(c_ldwb), 32'd1);

        // Reset during S_EX of ADD
        opcode = 3'b101; op = 2'b00;
        repeat (5) @(negedge clk);
        check("rstex_in_ex", 32'(en_C), 32'd1);
        rst = 1'b1;
        #1;
        check("rstex_async_pc", 32'({load_pc, pc_sel}), 32'd2);
        check("rstex_async_quiet", 32'(o1 & ~(19'd1 << B_LPC)), 32'd0);
        @(negedge clk);
        check("rstex_held_w_en", 32'(w_en), 32'd0);
        check("rstex_held_pc", 32'({load_pc, pc_sel}), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("rstex_refetch", 32'(waiting), 32'd1);

        // HALT
        opcode = 3'b111; op = 2'b00;
        repeat (3) @(negedge clk);
        check("halt_entered", 32'(halted), 32'd1);
        observe(50);
        check("halt_hold", 32'(c_halt), 32'd50);
        check("halt_strobes", 32'(c_strobe), 32'd0);

        // Illegal 000/00
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcode = 3'b000; op = 2'b00;
        @(negedge clk);
        check("ill_waiting", 32'(waiting), 32'd1);
        repeat (3) @(negedge clk);
        observe(50);
        check("ill_hold", 32'(c_halt), 32'd50);
        check("ill_strobes", 32'(c_strobe), 32'd0);

        // LDR at RAM_LAT=3
        rst3 = 1'b0;
        @(negedge clk);
        check("ldr3_waiting", 32'(waiting3), 32'd1);
        measure(1'b1, 60);
        check("ldr3_cycles", 32'(c_cyc), 32'd12);
        check("ldr3_mrd_addr0", 32'(c_zero), 32'd3);
        check("ldr3_wb_ram", 32'(c_ldwb), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
